// File: rtl/mmu_pkg.sv
// mmu_pkg: definitions shared by the data- and instruction-side page-table walkers.
// Holds the PTE bit positions, satp mode encodings, the walker FSM states and
// the {G,A,D,U,W,R,X} bit order used on the TLB write port.
package mmu_pkg;

   // Sv39/Sv48 PTE flag bit positions
   localparam int unsigned PteBitV = 0;
   localparam int unsigned PteBitR = 1;
   localparam int unsigned PteBitW = 2;
   localparam int unsigned PteBitX = 3;
   localparam int unsigned PteBitU = 4;
   localparam int unsigned PteBitG = 5;
   localparam int unsigned PteBitA = 6;
   localparam int unsigned PteBitD = 7;

   // satp.MODE encodings
   localparam logic [3:0] SatpModeSv39 = 4'd8;
   localparam logic [3:0] SatpModeSv48 = 4'd9;

   // Bit positions inside the 7-bit gaduwrx field
   localparam int unsigned GadBitX = 0;
   localparam int unsigned GadBitR = 1;
   localparam int unsigned GadBitW = 2;
   localparam int unsigned GadBitU = 3;
   localparam int unsigned GadBitD = 4;
   localparam int unsigned GadBitA = 5;
   localparam int unsigned GadBitG = 6;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } walk_state_e;

   // Repack PTE permission/status flags into the TLB write-port order.
   function automatic logic [6:0] pte_gaduwrx(input logic [63:0] pte);
      logic [6:0] g;
      g          = '0;
      g[GadBitG] = pte[PteBitG];
      g[GadBitA] = pte[PteBitA];
      g[GadBitD] = pte[PteBitD];
      g[GadBitU] = pte[PteBitU];
      g[GadBitW] = pte[PteBitW];
      g[GadBitR] = pte[PteBitR];
      g[GadBitX] = pte[PteBitX];
      return g;
   endfunction

endpackage

// File: rtl/dtlb_walker_if.sv
// dtlb_walker_if: request, PTE-read and TLB-write channels of the data-side walker.
// The master modport is the walker; the slave modport is the LSU/memory/TLB side.
interface dtlb_walker_if #(
   parameter int unsigned NPHYS = 44,
   parameter int unsigned VA_SZ = 48,
   parameter int unsigned RV    = 64
);
   // Miss request from the load/store unit
   logic              req_valid;
   logic              req_ready;
   logic [VA_SZ-1:12] req_vaddr;
   logic [15:0]       req_asid;
   logic              req_store;
   logic [NPHYS-1:12] satp_ppn;
   logic [3:0]        satp_mode;
   logic              walk_flush;

   // PTE read port
   logic              mem_rd_req;
   logic [NPHYS-1:3]  mem_rd_addr;
   logic              mem_rd_ack;
   logic [RV-1:0]     mem_rd_data;

   // TLB write port and walk completion
   logic              wr_entry;
   logic [VA_SZ-1:12] wr_vaddr;
   logic [15:0]       wr_asid;
   logic [NPHYS-1:12] wr_paddr;
   logic [6:0]        wr_gaduwrx;
   logic              wr_2mB;
   logic              wr_4mB;
   logic              wr_1gB;
   logic              wr_512gB;
   logic              done_valid;
   logic              done_fault;

   modport master (
      input  req_valid, req_vaddr, req_asid, req_store, satp_ppn, satp_mode, walk_flush,
      input  mem_rd_ack, mem_rd_data,
      output req_ready, mem_rd_req, mem_rd_addr,
      output wr_entry, wr_vaddr, wr_asid, wr_paddr, wr_gaduwrx,
      output wr_2mB, wr_4mB, wr_1gB, wr_512gB, done_valid, done_fault
   );

   modport slave (
      output req_valid, req_vaddr, req_asid, req_store, satp_ppn, satp_mode, walk_flush,
      output mem_rd_ack, mem_rd_data,
      input  req_ready, mem_rd_req, mem_rd_addr,
      input  wr_entry, wr_vaddr, wr_asid, wr_paddr, wr_gaduwrx,
      input  wr_2mB, wr_4mB, wr_1gB, wr_512gB, done_valid, done_fault
   );

endinterface

// File: rtl/dtlb_pte_check.sv
// dtlb_pte_check: combinational classification of one fetched PTE.
// Flags a page fault, tells leaf from pointer, and extracts the next-level PPN.
module dtlb_pte_check
   import mmu_pkg::*;
#(
   parameter int unsigned NPHYS = 44
) (
   input  logic [63:0]      pte,
   input  logic [1:0]       level,
   input  logic             store,
   output logic             fault,
   output logic             leaf,
   output logic [NPHYS-13:0] next_ppn
);

   logic misaligned;
   logic unused_rsw;

   // RSW bits are software-owned and never affect the walk
   assign unused_rsw = ^pte[9:8];
   assign next_ppn   = pte[NPHYS-3:10];

   // Superpage alignment: PPN bits below the leaf level must be zero.
   always_comb begin
      misaligned = 1'b0;
      case (level)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = |pte[18:10];
         2'd2:    misaligned = |pte[27:10];
         default: misaligned = |pte[36:10];
      endcase
   end

   // Fault/leaf classification of the PTE at the current level.
   always_comb begin
      leaf  = pte[PteBitR] | pte[PteBitW] | pte[PteBitX];
      fault = 1'b0;
      if (!pte[PteBitV] || (pte[PteBitW] && !pte[PteBitR])) fault = 1'b1;
      if ((|pte[63:54]) || (|pte[53:NPHYS-2]))              fault = 1'b1;
      if (!leaf && level == 2'd0)                           fault = 1'b1;
      if (leaf && (!pte[PteBitA] || (store && !pte[PteBitD]) || misaligned)) fault = 1'b1;
   end

endmodule

// File: rtl/dtlb_walker.sv
// dtlb_walker: page-table walker servicing one data-TLB miss at a time.
// Walks Sv39 tables through a single PTE read port and writes the leaf into the TLB.
// Define DTLB_WALKER_SV48_EN to accept satp_mode=9 (Sv48, walk from level 3, 512 GiB leaves).
module dtlb_walker
   import mmu_pkg::*;
#(
   parameter int unsigned NPHYS = 44,
   parameter int unsigned VA_SZ = 48,
   parameter int unsigned RV    = 64
) (
   input logic           clk,
   input logic           reset,
   dtlb_walker_if.master bus
);

   walk_state_e       state_q;
   logic [1:0]        level_q;
   logic [VA_SZ-1:12] vpn_q;
   logic [15:0]       asid_q;
   logic              store_q;
   logic              abort_q;
   logic [NPHYS-1:12] table_ppn_q;

   logic              req_ready_q;
   logic              mem_rd_req_q;
   logic [NPHYS-1:3]  mem_rd_addr_q;
   logic              wr_entry_q;
   logic              done_valid_q;
   logic              done_fault_q;
   logic [VA_SZ-1:12] wr_vaddr_q;
   logic [15:0]       wr_asid_q;
   logic [NPHYS-1:12] wr_paddr_q;
   logic [6:0]        wr_gaduwrx_q;
   logic              wr_2mb_q;
   logic              wr_1gb_q;
`ifdef DTLB_WALKER_SV48_EN
   logic              wr_512gb_q;
`endif

   logic [RV-1:0]     pte;
   logic              chk_fault;
   logic              chk_leaf;
   logic [NPHYS-13:0] chk_ppn;
   logic              mode_ok;
   logic [1:0]        start_level;

   // 9-bit VPN slice used to index the table at a given level.
   function automatic logic [8:0] vpn_at(input logic [VA_SZ-1:12] va, input logic [1:0] lvl);
      case (lvl)
         2'd0:    return va[20:12];
         2'd1:    return va[29:21];
         2'd2:    return va[38:30];
         default: return va[47:39];
      endcase
   endfunction

   assign pte = bus.mem_rd_data;

   dtlb_pte_check #(
      .NPHYS (NPHYS)
   ) u_pte_check (
      .pte      (pte),
      .level    (level_q),
      .store    (store_q),
      .fault    (chk_fault),
      .leaf     (chk_leaf),
      .next_ppn (chk_ppn)
   );

   // Decode the translation mode presented alongside a new miss.
   always_comb begin
      mode_ok     = 1'b0;
      start_level = 2'd2;
      if (bus.satp_mode == SatpModeSv39) mode_ok = 1'b1;
`ifdef DTLB_WALKER_SV48_EN
      if (bus.satp_mode == SatpModeSv48) begin
         mode_ok     = 1'b1;
         start_level = 2'd3;
      end
`endif
   end

   // Walk FSM with all outputs registered; done/wr pulses last exactly the DONE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         level_q       <= '0;
         vpn_q         <= '0;
         asid_q        <= '0;
         store_q       <= 1'b0;
         abort_q       <= 1'b0;
         table_ppn_q   <= '0;
         req_ready_q   <= 1'b1;
         mem_rd_req_q  <= 1'b0;
         mem_rd_addr_q <= '0;
         wr_entry_q    <= 1'b0;
         done_valid_q  <= 1'b0;
         done_fault_q  <= 1'b0;
         wr_vaddr_q    <= '0;
         wr_asid_q     <= '0;
         wr_paddr_q    <= '0;
         wr_gaduwrx_q  <= '0;
         wr_2mb_q      <= 1'b0;
         wr_1gb_q      <= 1'b0;
`ifdef DTLB_WALKER_SV48_EN
         wr_512gb_q    <= 1'b0;
`endif
      end else begin
         wr_entry_q   <= 1'b0;
         done_valid_q <= 1'b0;
         done_fault_q <= 1'b0;
         case (state_q)
            StIdle: begin
               // A flush in the same cycle as a request wins; the request is not taken.
               if (!bus.walk_flush && bus.req_valid) begin
                  vpn_q       <= bus.req_vaddr;
                  asid_q      <= bus.req_asid;
                  store_q     <= bus.req_store;
                  table_ppn_q <= bus.satp_ppn;
                  level_q     <= start_level;
                  req_ready_q <= 1'b0;
                  if (!mode_ok) begin
                     state_q      <= StDone;
                     done_valid_q <= 1'b1;
                     done_fault_q <= 1'b1;
                  end else begin
                     state_q       <= StReq;
                     mem_rd_req_q  <= 1'b1;
                     mem_rd_addr_q <= {bus.satp_ppn, vpn_at(bus.req_vaddr, start_level)};
                  end
               end
            end
            StReq: begin
               if (bus.walk_flush) begin
                  state_q      <= StIdle;
                  mem_rd_req_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end else begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               // An outstanding read cannot be withdrawn, so a flush here is remembered.
               if (bus.walk_flush) abort_q <= 1'b1;
               if (bus.mem_rd_ack) begin
                  mem_rd_req_q <= 1'b0;
                  if (abort_q || bus.walk_flush) begin
                     state_q     <= StIdle;
                     abort_q     <= 1'b0;
                     req_ready_q <= 1'b1;
                  end else if (chk_fault) begin
                     state_q      <= StDone;
                     done_valid_q <= 1'b1;
                     done_fault_q <= 1'b1;
                  end else if (!chk_leaf) begin
                     state_q       <= StReq;
                     level_q       <= level_q - 2'd1;
                     table_ppn_q   <= chk_ppn;
                     mem_rd_req_q  <= 1'b1;
                     mem_rd_addr_q <= {chk_ppn, vpn_at(vpn_q, level_q - 2'd1)};
                  end else begin
                     state_q      <= StDone;
                     wr_entry_q   <= 1'b1;
                     done_valid_q <= 1'b1;
                     wr_vaddr_q   <= vpn_q;
                     wr_asid_q    <= asid_q;
                     wr_paddr_q   <= chk_ppn;
                     wr_gaduwrx_q <= pte_gaduwrx(pte);
                     wr_2mb_q     <= (level_q == 2'd1);
                     wr_1gb_q     <= (level_q == 2'd2);
`ifdef DTLB_WALKER_SV48_EN
                     wr_512gb_q   <= (level_q == 2'd3);
`endif
                  end
               end
            end
            StDone: begin
               state_q     <= StIdle;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= StIdle;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.mem_rd_req  = mem_rd_req_q;
   assign bus.mem_rd_addr = mem_rd_addr_q;
   assign bus.wr_entry    = wr_entry_q;
   assign bus.wr_vaddr    = wr_vaddr_q;
   assign bus.wr_asid     = wr_asid_q;
   assign bus.wr_paddr    = wr_paddr_q;
   assign bus.wr_gaduwrx  = wr_gaduwrx_q;
   assign bus.wr_2mB      = wr_2mb_q;
   assign bus.wr_4mB      = 1'b0;
   assign bus.wr_1gB      = wr_1gb_q;
`ifdef DTLB_WALKER_SV48_EN
   assign bus.wr_512gB    = wr_512gb_q;
`else
   assign bus.wr_512gB    = 1'b0;
`endif
   assign bus.done_valid  = done_valid_q;
   assign bus.done_fault  = done_fault_q;

endmodule
